alu_seq: RTL and testbench

- Multi-byte operation sequencer that drives the existing 8-bit combinational ALU.
- Accepts one wide request (A, B, op, carry/shift-in) over a valid/ready handshake.
- Issues the request to the ALU one byte per cycle, chaining carry or shift bits between passes, and assembles the wide result.
- Sits between the decode/control stage and the ALU, so wide ADD/RSH/XOR/AND/COMPARE/MOVE work without extra instructions.

---
 rtl/alu_seq_pkg.sv | 30 +++
 rtl/alu_seq_byteidx.sv | 37 +++
 rtl/alu_seq.sv | 144 ++++++++++++++
 tb/tb_alu_seq.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared op codes and sequencer state for the wide ALU sequencer.
// op_t is the 4-bit {OP,funct} code; kNOP decodes to ALU default (zero).
package alu_seq_pkg;

  typedef logic [3:0] op_t;

  localparam op_t kADD     = 4'b0000;
  localparam op_t kRSH     = 4'b0001;
  localparam op_t kXOR     = 4'b0100;
  localparam op_t kAND     = 4'b0101;
  localparam op_t kCOMPARE = 4'b1000;
  localparam op_t kMove    = 4'b1001;
  localparam op_t kNOP     = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } seq_state_t;

  function automatic logic op_known(op_t op);
    return op inside {kADD, kRSH, kXOR,
                      kAND, kCOMPARE, kMove};
  endfunction

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_seq_byteidx.sv
// Byte-index counter for alu_seq: loads 0 (ascending) or N_BYTES-1
// (descending), steps once per pass, flags the last pass.
// Ports: clk, rst, load, desc, step -> idx, last_pass.
module alu_seq_byteidx
  import alu_seq_pkg::*;
#(
  parameter int N_BYTES = 2,
  localparam int IW = idx_w(N_BYTES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          desc,
  input  logic          step,
  output logic [IW-1:0] idx,
  output logic          last_pass
);

  localparam logic [IW-1:0] TOP = IW'(N_BYTES - 1);

  logic desc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      desc_q <= 1'b0;
    end else if (load) begin
      desc_q <= desc;
      idx    <= desc ? TOP : '0;
    end else if (step) begin
      idx <= desc_q ? idx - IW'(1) : idx + IW'(1);
    end
  end

  assign last_pass = desc_q ? (idx == '0) : (idx == TOP);

endmodule

// File: rtl/alu_seq.sv
// Multi-byte sequencer driving an external 8-bit ALU one byte per cycle.
// Ports: req_* (wide request, valid/ready), rsp_* (wide result,
// valid/ready), alu_* (byte drive to / result from the ALU).
// Optional macro ALU_SEQ_CNT_EN adds op_count[15:0], the count of
// completed response handshakes.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int N_BYTES = 2,
  localparam int W  = 8 * N_BYTES,
  localparam int IW = idx_w(N_BYTES)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [3:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  input  logic         req_cin,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_cout,
  output logic         rsp_zero,
  output logic [7:0]   alu_a,
  output logic [7:0]   alu_b,
  output logic [1:0]   alu_op,
  output logic [1:0]   alu_funct,
  output logic         alu_sc_in,
  input  logic [7:0]   alu_out,
  input  logic         alu_sc_out,
  input  logic         alu_zero
`ifdef ALU_SEQ_CNT_EN
  ,
  output logic [15:0]  op_count
`endif
);

  seq_state_t state_q, state_d;

  op_t                     op_q;
  logic [N_BYTES-1:0][7:0] a_q, b_q, res_q;
  logic                    sc_q;
  logic                    zacc_q;

  logic [IW-1:0] idx;
  logic          last_pass;
  logic          accept;
  logic          pass;
  logic          chain;
  op_t           drv_op;

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign pass      = (state_q == EXEC);

  alu_seq_byteidx #(
    .N_BYTES (N_BYTES)
  ) u_idx (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .desc      (req_op == kRSH),
    .step      (pass),
    .idx       (idx),
    .last_pass (last_pass)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept)    state_d = EXEC;
      EXEC: if (last_pass) state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  // sc_q carries cin into the first pass, then each pass's carry/shift
  // out into the next; after the last pass it is the final carry-out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= kNOP;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      sc_q   <= 1'b0;
      zacc_q <= 1'b0;
    end else if (accept) begin
      op_q   <= req_op;
      a_q    <= req_a;
      b_q    <= req_b;
      sc_q   <= req_cin;
      zacc_q <= 1'b1;
    end else if (pass) begin
      for (int i = 0; i < N_BYTES; i++)
        if (idx == IW'(i)) res_q[i] <= alu_out;
      sc_q   <= alu_sc_out;
      zacc_q <= zacc_q & alu_zero;
    end
  end

  assign drv_op = op_known(op_q) ? op_q : kNOP;

  always_comb begin
    alu_a               = '0;
    alu_b               = '0;
    {alu_op, alu_funct} = kNOP;
    alu_sc_in           = 1'b0;
    if (pass) begin
      for (int i = 0; i < N_BYTES; i++) begin
        if (idx == IW'(i)) begin
          alu_a = a_q[i];
          alu_b = b_q[i];
        end
      end
      {alu_op, alu_funct} = drv_op;
      alu_sc_in           = sc_q;
    end
  end

  // Compare yields 0/1 per byte; the wide answer collapses to one bit.
  assign chain     = (op_q == kADD) || (op_q == kRSH);
  assign rsp_valid = (state_q == RESP);
  assign rsp_cout  = sc_q & chain;
  assign rsp_zero  = zacc_q;
  assign rsp_data  = (op_q == kCOMPARE) ? W'(|res_q) : res_q;

`ifdef ALU_SEQ_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      op_count <= '0;
    else if (rsp_valid && rsp_ready)
      op_count <= op_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: vector table, hand-written corner sequences,
// and random requests against a wide-arithmetic reference model.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        req_valid, req_ready, req_cin;
  logic [3:0]  req_op;
  logic [15:0] req_a, req_b, rsp_data;
  logic        rsp_valid, rsp_ready, rsp_cout, rsp_zero;
  logic [7:0]  alu_a, alu_b, alu_out;
  logic [1:0]  alu_op, alu_funct;
  logic        alu_sc_in, alu_sc_out, alu_zero;

  logic        req_valid1, req_ready1, req_cin1;
  logic [3:0]  req_op1;
  logic [7:0]  req_a1, req_b1, rsp_data1;
  logic        rsp_valid1, rsp_ready1, rsp_cout1, rsp_zero1;
  logic [7:0]  alu_a1, alu_b1, alu_out1;
  logic [1:0]  alu_op1, alu_funct1;
  logic        alu_sc_in1, alu_sc_out1, alu_zero1;

`ifdef ALU_SEQ_CNT_EN
  logic [15:0] op_count, op_count1;
`endif

  int nvec = 0;
  int nmis = 0;
  int exp_cnt = 0;

  alu_seq #(.N_BYTES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_cout(rsp_cout),
    .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_funct(alu_funct), .alu_sc_in(alu_sc_in),
    .alu_out(alu_out), .alu_sc_out(alu_sc_out),
    .alu_zero(alu_zero)
`ifdef ALU_SEQ_CNT_EN
    , .op_count(op_count)
`endif
  );

  alu_seq #(.N_BYTES(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1),
    .req_op(req_op1), .req_a(req_a1), .req_b(req_b1),
    .req_cin(req_cin1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_data(rsp_data1), .rsp_cout(rsp_cout1),
    .rsp_zero(rsp_zero1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1),
    .alu_funct(alu_funct1), .alu_sc_in(alu_sc_in1),
    .alu_out(alu_out1), .alu_sc_out(alu_sc_out1),
    .alu_zero(alu_zero1)
`ifdef ALU_SEQ_CNT_EN
    , .op_count(op_count1)
`endif
  );

  // Stand-in for the external 8-bit ALU: {sc_out, zero, out}.
  function automatic logic [9:0] alu_f(logic [3:0] code,
      logic [7:0] a, logic [7:0] b, logic si);
    logic [8:0] s;
    logic [7:0] o;
    logic       c;
    o = 8'h00;
    c = 1'b0;
    case (code)
      kADD: begin
        s = {1'b0, a} + {1'b0, b} + 9'(si);
        o = s[7:0];
        c = s[8];
      end
      kRSH: begin
        o = {si, a[7:1]};
        c = a[0];
      end
      kXOR:     o = a ^ b;
      kAND:     o = a & b;
      kMove:    o = a;
      kCOMPARE: o = (a != b) ? 8'h01 : 8'h00;
      default:  o = 8'h00;
    endcase
    return {c, (o == 8'h00), o};
  endfunction

  assign {alu_sc_out, alu_zero, alu_out} =
    alu_f({alu_op, alu_funct}, alu_a, alu_b, alu_sc_in);
  assign {alu_sc_out1, alu_zero1, alu_out1} =
    alu_f({alu_op1, alu_funct1}, alu_a1, alu_b1, alu_sc_in1);

  // Whole-word reference: {zero, cout, data}.
  function automatic logic [17:0] ref_f(logic [3:0] op,
      logic [15:0] a, logic [15:0] b, logic cin);
    logic [16:0] s;
    logic [15:0] d;
    logic        c;
    d = 16'h0000;
    c = 1'b0;
    case (op)
      kADD: begin
        s = {1'b0, a} + {1'b0, b} + 17'(cin);
        d = s[15:0];
        c = s[16];
      end
      kRSH: begin
        d = {cin, a[15:1]};
        c = a[0];
      end
      kXOR:     d = a ^ b;
      kAND:     d = a & b;
      kMove:    d = a;
      kCOMPARE: d = (a == b) ? 16'h0000 : 16'h0001;
      default:  d = 16'h0000;
    endcase
    return {(d == 16'h0000), c, d};
  endfunction

  task automatic chk(string name, logic [31:0] got,
      logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fail_now(string name);
    nvec++;
    nmis++;
    $display("FAIL %s: timeout", name);
  endtask

  task automatic run(input logic [3:0] op,
      input logic [15:0] a, input logic [15:0] b,
      input logic cin, input int hold,
      output logic [15:0] d, output logic c,
      output logic z, output int lat);
    int t;
    @(negedge clk);
    req_valid = 1'b1;
    req_op = op; req_a = a; req_b = b; req_cin = cin;
    t = 0;
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) fail_now("accept");
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) fail_now("rsp_valid");
    lat = lat + 1;
    d = rsp_data; c = rsp_cout; z = rsp_zero;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_data", rsp_data, d);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    exp_cnt++;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] d;
    logic        c;
    logic        z;
  } vec_t;

  vec_t tbl[$];
  op_t  known[6] = '{kADD, kRSH, kXOR, kAND, kCOMPARE, kMove};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] d;
    logic        c, z;
    int          lat, t;
    logic [3:0]  op;
    logic [15:0] a, b;
    logic        cin;
    logic [17:0] r;

    rst = 1'b1;
    req_valid = 0; req_op = 0; req_a = 0; req_b = 0; req_cin = 0;
    rsp_ready = 0;
    req_valid1 = 0; req_op1 = 0; req_a1 = 0; req_b1 = 0;
    req_cin1 = 0; rsp_ready1 = 0;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_cout", rsp_cout, 0);
    chk("rst_rsp_zero", rsp_zero, 0);
    chk("rst_alu_drive", {alu_op, alu_funct, alu_a, alu_b, alu_sc_in},
        {kNOP, 17'h0});
`ifdef ALU_SEQ_CNT_EN
    chk("rst_op_count", op_count, 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", req_ready, 1);

    tbl.push_back('{kADD, 16'h00FF, 16'h0001, 0, 16'h0100, 0, 0});
    tbl.push_back('{kADD, 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 1});
    tbl.push_back('{kRSH, 16'h0101, 16'h0000, 1, 16'h8080, 1, 0});
    tbl.push_back('{kCOMPARE, 16'h1234, 16'h1234, 0, 16'h0000, 0, 1});
    tbl.push_back('{kCOMPARE, 16'h1234, 16'h1235, 0, 16'h0001, 0, 0});
    tbl.push_back('{kCOMPARE, 16'h1234, 16'h1334, 0, 16'h0001, 0, 0});
    tbl.push_back('{kXOR, 16'hF0F0, 16'hFF00, 0, 16'h0FF0, 0, 0});
    tbl.push_back('{kAND, 16'hF0F0, 16'hFF00, 1, 16'hF000, 0, 0});
    tbl.push_back('{kMove, 16'hABCD, 16'h1234, 0, 16'hABCD, 0, 0});
    tbl.push_back('{4'b1010, 16'hFFFF, 16'hFFFF, 1, 16'h0000, 0, 1});

    foreach (tbl[i]) begin
      run(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin, 1, d, c, z, lat);
      chk($sformatf("v%0d_data", i), d, tbl[i].d);
      chk($sformatf("v%0d_cout", i), c, tbl[i].c);
      chk($sformatf("v%0d_zero", i), z, tbl[i].z);
      chk($sformatf("v%0d_lat", i), lat, 3);
    end
`ifdef ALU_SEQ_CNT_EN
    chk("tbl_op_count", op_count, exp_cnt);
`endif

    // RSH runs top byte first; carry out of byte 1 shifts into byte 0.
    @(negedge clk);
    req_valid = 1; req_op = kRSH; req_a = 16'h0102;
    req_b = 16'h0000; req_cin = 0;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    chk("rsh_p1_a", alu_a, 8'h01);
    chk("rsh_p1_sc", alu_sc_in, 0);
    chk("rsh_p1_op", {alu_op, alu_funct}, kRSH);
    @(negedge clk);
    chk("rsh_p2_a", alu_a, 8'h02);
    chk("rsh_p2_sc", alu_sc_in, 1);
    @(negedge clk);
    chk("rsh_valid", rsp_valid, 1);
    chk("rsh_data", rsp_data, 16'h0081);
    chk("rsh_cout", rsp_cout, 0);
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
    exp_cnt++;

    // Unknown code must reach the ALU as kNOP.
    @(negedge clk);
    req_valid = 1; req_op = 4'b0110; req_a = 16'h5555;
    req_b = 16'hAAAA; req_cin = 1;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    chk("unk_alu_op", {alu_op, alu_funct}, kNOP);
    @(negedge clk);
    @(negedge clk);
    chk("unk_data", rsp_data, 0);
    chk("unk_zero", rsp_zero, 1);
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
    exp_cnt++;

    // Backpressure with a second request waiting.
    @(negedge clk);
    req_valid = 1; req_op = kADD; req_a = 16'h1111;
    req_b = 16'h2222; req_cin = 0;
    @(posedge clk);
    #1 req_a = 16'h0005; req_b = 16'h0007;
    @(negedge clk);
    chk("bp_busy_ready", req_ready, 0);
    t = 0;
    while (!rsp_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!rsp_valid) fail_now("bp_rsp_valid");
    repeat (5) begin
      chk("bp_data", rsp_data, 16'h3333);
      chk("bp_ready", req_ready, 0);
      @(negedge clk);
    end
    chk("bp_valid_held", rsp_valid, 1);
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
    exp_cnt++;
    @(negedge clk);
    chk("bp_after_valid", rsp_valid, 0);
    chk("bp_after_ready", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 0;
    t = 0;
    @(negedge clk);
    while (!rsp_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("bp_second_data", rsp_data, 16'h000C);
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
    exp_cnt++;

    // Reset after the first pass of an ADD.
    @(negedge clk);
    req_valid = 1; req_op = kADD; req_a = 16'h00FF;
    req_b = 16'h0001; req_cin = 0;
    @(posedge clk);
    #1 req_valid = 0;
    @(posedge clk);
    #1 rst = 1;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_alu", {alu_op, alu_funct}, kNOP);
    @(negedge clk);
    rst = 0;
    exp_cnt = 0;
    repeat (4) @(negedge clk);
    chk("post_rst_valid", rsp_valid, 0);
    chk("post_rst_ready", req_ready, 1);
    run(kADD, 16'h0001, 16'h0001, 0, 0, d, c, z, lat);
    chk("post_rst_add", d, 16'h0002);
`ifdef ALU_SEQ_CNT_EN
    chk("post_rst_count", op_count, 1);
`endif

    // Single-byte build: two-cycle latency.
    @(negedge clk);
    req_valid1 = 1; req_op1 = kADD; req_a1 = 8'hFF;
    req_b1 = 8'h01; req_cin1 = 0;
    @(posedge clk);
    #1 req_valid1 = 0;
    @(negedge clk);
    chk("n1_valid_early", rsp_valid1, 0);
    @(negedge clk);
    chk("n1_valid", rsp_valid1, 1);
    chk("n1_data", rsp_data1, 8'h00);
    chk("n1_cout", rsp_cout1, 1);
    chk("n1_zero", rsp_zero1, 1);
    rsp_ready1 = 1;
    @(posedge clk);
    #1 rsp_ready1 = 0;
    @(negedge clk);
    req_valid1 = 1; req_op1 = 4'b1100; req_a1 = 8'h7E;
    req_b1 = 8'h81; req_cin1 = 1;
    @(posedge clk);
    #1 req_valid1 = 0;
    @(negedge clk);
    chk("n1_unk_alu", {alu_op1, alu_funct1}, kNOP);
    @(negedge clk);
    chk("n1_unk_data", rsp_data1, 0);
    chk("n1_unk_cout", rsp_cout1, 0);
    chk("n1_unk_zero", rsp_zero1, 1);
    rsp_ready1 = 1;
    @(posedge clk);
    #1 rsp_ready1 = 0;

    // Random requests.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(0, 15));
      else op = known[$urandom_range(0, 5)];
      a = 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      cin = 1'($urandom_range(0, 1));
      r = ref_f(op, a, b, cin);
      run(op, a, b, cin, $urandom_range(0, 2), d, c, z, lat);
      chk($sformatf("rnd%0d_op%h_data", i, op), d, r[15:0]);
      chk($sformatf("rnd%0d_op%h_cout", i, op), c, r[16]);
      chk($sformatf("rnd%0d_op%h_zero", i, op), z, r[17]);
    end
`ifdef ALU_SEQ_CNT_EN
    chk("final_op_count", op_count, exp_cnt);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
